// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer and flush.
// Define PIPE_STAGE_STALL_CNT_EN to build the back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic accept;
  logic consume;
  logic st_empty;
  logic st_one;
  logic st_two;

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : CTRL_NOP;

  assign accept  = in_valid & in_ready;
  assign consume = m_valid_q & out_ready;

  assign st_empty = !m_valid_q;
  assign st_one   = m_valid_q & !s_valid_q;
  assign st_two   = m_valid_q & s_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = CTRL_NOP;
      s_ctrl_d  = CTRL_NOP;
    end else begin
      unique case (1'b1)
        st_empty: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = in_ctrl;
          end
        end
        st_one: begin
          if (accept && consume) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = in_ctrl;
          end else if (consume) begin
            m_valid_d = 1'b0;
          end
        end
        st_two: begin
          if (consume) begin
            s_valid_d = 1'b0;
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      m_ctrl_q  <= CTRL_NOP;
      s_ctrl_q  <= CTRL_NOP;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        stall;

  assign stall = m_valid_q & !out_ready & !flush;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus random traffic,
// checked against a queue-based model of the stage.
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 8;
`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [31:0]   stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mcnt;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_ctrl", {56'd0, out_ctrl},
        {56'd0, (q.size() > 0) ? q[0].c : 8'h00});
    if (q.size() > 0) chk("out_data", out_data, q[0].d);
    chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, mcnt});
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy,
                      input logic fl);
    bit   acc, con;
    ent_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1 check_outs();
    acc = v && (q.size() < 2);
    con = (q.size() > 0) && ordy;
    @(posedge clk);
    if (CNT_EN && q.size() > 0 && !ordy && !fl &&
        mcnt != 32'hFFFF_FFFF) mcnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic          pv, pr, pf, was_rdy, pend;
    logic [DW-1:0] pd;
    logic [CW-1:0] pc;
    n_chk = 0; n_fail = 0; mcnt = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("rst_data", out_data, 64'h0);
    rst = 1'b1;

    for (int i = 1; i <= 8; i++)
      step(1'b1, DW'(i), CW'(8'h10 + i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    step(1'b1, 64'hAA, 8'h03, 1'b0, 1'b0);
    step(1'b1, 64'hBB, 8'h05, 1'b0, 1'b0);
    #1 chk("bp_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold", out_data, 64'hAA);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    #1 chk("bp_second", out_data, 64'hBB);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    step(1'b1, 64'hA1, 8'h09, 1'b0, 1'b0);
    step(1'b1, 64'hB1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 64'hCC, 8'h07, 1'b0, 1'b1);
    #1 chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ctrl", {56'd0, out_ctrl}, 64'h0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    step(1'b1, 64'h11, 8'h21, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 64'hDEAD, 8'hFF, 1'b1, 1'b0);
    #1 chk("bub_ctrl", {56'd0, out_ctrl}, 64'h0);
    step(1'b1, 64'h22, 8'h31, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    step(1'b1, 64'h71, 8'h41, 1'b0, 1'b0);
    step(1'b1, 64'h72, 8'h42, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_ready", {63'd0, in_ready}, 64'd1);
    chk("ar_ctrl", {56'd0, out_ctrl}, 64'h0);
    chk("ar_data", out_data, 64'h0);
    chk("ar_cnt", {32'd0, stall_cnt}, 64'h0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    step(1'b1, 64'h55, 8'h51, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, '0, '0, 1'b0, 1'b0);
    #1 chk("cnt5", {32'd0, stall_cnt}, CNT_EN ? 64'd5 : 64'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    #1 force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    mcnt = 32'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, '0, 1'b0, 1'b0);
    #1 chk("cnt_sat", {32'd0, stall_cnt},
           CNT_EN ? 64'hFFFF_FFFF : 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    pend = 1'b0;
    pv = 1'b0; pd = '0; pc = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = {$urandom, $urandom};
        pc = CW'($urandom);
      end
      pr = ($urandom_range(0, 2) != 0);
      pf = ($urandom_range(0, 19) == 0);
      was_rdy = (q.size() < 2);
      step(pv, pd, pc, pr, pf);
      pend = pv && !was_rdy && !pf;
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor of the fixed-field inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- One instance holds a DATA_W payload (addresses, ALU result, store data) and a CTRL_W control vector (write enables, read enables, Mem2R), with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under back-pressure, plus a synchronous flush for branch and exception squash.
- Sits between any two pipeline stages; the downstream stage sees a NOP control vector whenever the stage is empty.

Parameters:
- DATA_W, 64: payload width in bits (≥1).
- CTRL_W, 8: control-vector width in bits (≥1).
- CTRL_NOP, {CTRL_W{1'b0}}: control value presented while empty, flushed or in reset. All enables are deasserted.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control vector
- out_valid  out  1  stage holds an instruction for downstream
- out_ready  in  1  downstream consumes this cycle
- out_data  out  DATA_W  head-entry payload
- out_ctrl  out  CTRL_W  head-entry control; CTRL_NOP when out_valid=0
- stall_cnt  out  32  back-pressure cycle counter (see Optional Feature)

Behaviour:
- Storage: main entry (m_valid, m_data, m_ctrl) and skid entry (s_valid, s_data, s_ctrl).
- Outputs:
  - out_valid = m_valid; out_data = m_data.
  - out_ctrl = m_valid ? m_ctrl : CTRL_NOP.
  - in_ready = !s_valid. Driven from a register, with no combinational path from out_ready.
- Transfers: accept = in_valid & in_ready; consume = m_valid & out_ready.
- States are encoded by the valid bits: EMPTY (m=0,s=0), ONE (m=1,s=0), TWO (m=1,s=1). The combination m=0,s=1 is illegal.
- EMPTY:
  - accept → ONE; the input loads main.
- ONE:
  - accept & consume → stay ONE; the input loads main.
  - accept & !consume → TWO; the input loads skid.
  - !accept & consume → EMPTY.
  - otherwise hold.
- TWO (in_ready=0, no accept possible):
  - consume → ONE; skid moves to main.
  - otherwise hold.
- Ordering is strict FIFO. Latency is 1 cycle from accept to out_valid when the stage was EMPTY or was consumed the same cycle. Throughput is 1 instruction/cycle while out_ready=1.
- Holding: while out_valid=1 and out_ready=0, out_data and out_ctrl are stable.
- flush:
  - Next edge: m_valid=s_valid=0; m_ctrl and s_ctrl ← CTRL_NOP; data registers are don't-care.
  - flush has priority over a simultaneous accept; that input is dropped.
  - in_ready in the flush cycle reflects the pre-flush state.
  - In the cycle after flush: out_valid=0, out_ctrl=CTRL_NOP, in_ready=1.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - Immediately: out_valid=0, in_ready=1 (s_valid=0), out_ctrl=CTRL_NOP, out_data=0, stall_cnt=0.
  - Reset release is synchronised by the system; the first accept is possible on the first edge with rst=1.
- Input rules:
  - in_data and in_ctrl are ignored when in_valid=0.
  - The upstream stage must hold in_valid, in_data and in_ctrl stable while in_ready=0.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every edge where out_valid=1 & out_ready=0 & flush=0.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - It is cleared only by reset.
- Not defined:
  - No counter logic is synthesised and stall_cnt is tied to 32'h0.
  - The port list is unchanged.

Test Plan:
- Reset: assert rst=0 mid-stream with TWO occupied → same cycle out_valid=0, in_ready=1, out_ctrl=CTRL_NOP, stall_cnt=0.
- Streaming: out_ready=1, 8 back-to-back beats in_data=1..8 → out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Back-pressure: out_ready=0 while sending A=0xAA, B=0xBB →
  - after 2 edges in_ready=0 (TWO) and out_data holds 0xAA;
  - raising out_ready then delivers 0xAA then 0xBB with nothing lost.
- Flush in TWO with in_valid=1 (C=0xCC) same cycle → next cycle out_valid=0, out_ctrl=0x00, in_ready=1, and 0xCC never appears.
- Bubble: in_valid=0 for 3 cycles between beats, with in_ctrl=0xFF driven during the gap → out_ctrl=0x00 in every empty cycle.
- Counter (macro defined): hold out_ready=0 for 5 cycles with one entry held → stall_cnt=5.
  - Preload by force to 32'hFFFF_FFFE, then 3 more stall cycles → stall_cnt=32'hFFFF_FFFF.
  - With the macro undefined, stall_cnt stays 0.
